coax_tx_arbiter: RTL and testbench

COAX_TX_ARBITER -- requirements
Module: coax_tx_arbiter

---
 rtl/coax_pkg.sv | 21 ++
 rtl/coax_rr_pick.sv | 18 +
 rtl/coax_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_coax_tx_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coax_pkg.sv
// Shared types and constants for the coax transmit arbiter.
// State enumeration, default word width and requester-index type.
package coax_pkg;

  localparam int WORD_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ABORT = 2'd3
  } coax_state_t;

  // Index of a requester: 0 or 1.
  typedef logic coax_idx_t;

  function automatic coax_idx_t onehot_to_idx(input logic [1:0] oh);
    return oh[1];
  endfunction

endpackage

// File: rtl/coax_rr_pick.sv
// Two-way round-robin pick: when both requesters are valid, the one not
// served last wins; otherwise the single valid requester wins.
module coax_rr_pick
  import coax_pkg::*;
(
  input  logic [1:0] valid,
  input  coax_idx_t  last,
  output logic [1:0] winner
);

  always_comb begin
    winner = valid;
    if (valid == 2'b11) begin
      winner = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/coax_tx_arbiter.sv
// Frame-atomic round-robin arbiter of two requesters onto one coax transmitter.
// Optional idle-word timeout/abort enabled by macro COAX_TX_ARB_TIMEOUT_EN.
module coax_tx_arbiter
  import coax_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int WORD_WIDTH     = coax_pkg::WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WORD_WIDTH-1:0] req0_data,
  input  logic                  req0_valid,
  input  logic                  req0_last,
  output logic                  req0_ready,
  input  logic [WORD_WIDTH-1:0] req1_data,
  input  logic                  req1_valid,
  input  logic                  req1_last,
  output logic                  req1_ready,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  input  logic                  tx_ready,
  input  logic                  tx_active,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic                  tx_abort,
  output logic                  error,
  output coax_state_t           state
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  coax_state_t state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  coax_idx_t   last_q, last_d;
  logic [1:0]  pick;
  coax_idx_t   sel;
  logic        g_valid, g_last, xfer;
  logic [WORD_WIDTH-1:0] g_data;

  coax_rr_pick u_pick (
    .valid  ({req1_valid, req0_valid}),
    .last   (last_q),
    .winner (pick)
  );

  // Handshake: a word moves when tx_valid && tx_ready are high on a rising
  // edge; reqN_ready mirrors tx_ready for the granted requester only, so the
  // requester and transmitter see the same transfer in the same cycle.
  assign sel     = onehot_to_idx(grant_q);
  assign g_valid = sel ? req1_valid : req0_valid;
  assign g_last  = sel ? req1_last  : req0_last;
  assign g_data  = sel ? req1_data  : req0_data;
  assign xfer    = (state_q == ST_GRANT) && g_valid && tx_ready;

  assign tx_valid   = (state_q == ST_GRANT) && g_valid;
  assign tx_last    = (state_q == ST_GRANT) && g_last;
  assign tx_data    = (state_q == ST_GRANT) ? g_data : '0;
  assign req0_ready = (state_q == ST_GRANT) && grant_q[0] && tx_ready;
  assign req1_ready = (state_q == ST_GRANT) && grant_q[1] && tx_ready;
  assign grant      = grant_q;
  assign busy       = (state_q != ST_IDLE);
  assign state      = state_q;

`ifdef COAX_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          error_q;
  logic          timeout_hit;

  // The cycle whose increment would make the count reach the limit.
  assign timeout_hit = !g_valid && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      if (state_q != ST_GRANT || xfer) begin
        cnt_q <= '0;
      end else if (!g_valid) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == ST_ABORT) begin
        error_q <= 1'b1;
      end
    end
  end

  assign tx_abort = (state_q == ST_ABORT);
  assign error    = error_q;
`else
  assign tx_abort = 1'b0;
  assign error    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_d = pick;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (xfer && g_last) begin
          last_d  = sel;
          state_d = ST_DRAIN;
        end
`ifdef COAX_TX_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = ST_ABORT;
        end
`endif
      end
      ST_ABORT: begin
        last_d  = sel;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Grant is dropped only once the line has gone quiet.
        if (!tx_active) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_coax_tx_arbiter.sv
// Self-checking bench for coax_tx_arbiter: directed scenarios plus randomized
// frames, with per-requester expected-word queues checked by a monitor.
module tb_coax_tx_arbiter;
  import coax_pkg::*;

  localparam int W  = 10;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  req0_data, req1_data, tx_data;
  logic          req0_valid, req0_last, req0_ready;
  logic          req1_valid, req1_last, req1_ready;
  logic          tx_valid, tx_last, tx_ready, tx_active;
  logic [1:0]    grant;
  logic          busy, tx_abort, error;
  coax_state_t   state;

  coax_tx_arbiter #(.TIMEOUT_CYCLES(TO), .WORD_WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .tx_active(tx_active),
    .grant(grant), .busy(busy), .tx_abort(tx_abort), .error(error), .state(state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int tests  = 0;
  int failed = 0;
  logic [W:0] exp0_q[$];
  logic [W:0] exp1_q[$];
  int owner_log[$];
  bit in_frame = 1'b0;
  int cur_owner = 0;
  int pred_last = 1;   // predicted last-served index
  bit rand_env = 1'b0;

  int mon_idx;
  logic [W:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected word of the granted requester on each transfer.
  always @(negedge clk) begin
    if (reset_n) begin
      check("ready0_rule", 32'(req0_ready & ~(grant[0] & tx_ready)), 0);
      check("ready1_rule", 32'(req1_ready & ~(grant[1] & tx_ready)), 0);
      check("valid_needs_busy", 32'(tx_valid & ~busy), 0);
      if (tx_valid && tx_ready) begin
        check("grant_onehot", $countones(grant), 1);
        mon_idx = grant[1] ? 1 : 0;
        if (in_frame) begin
          check("frame_atomic", mon_idx, cur_owner);
        end else begin
          owner_log.push_back(mon_idx);
          in_frame  = 1'b1;
          cur_owner = mon_idx;
        end
        if ((mon_idx == 0 && exp0_q.size() == 0) || (mon_idx == 1 && exp1_q.size() == 0)) begin
          tests++;
          failed++;
          $display("FAIL unexpected_word: req%0d sent 0x%0h, required no transfer", mon_idx, {tx_last, tx_data});
        end else begin
          mon_exp = (mon_idx == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
          check("tx_word", {tx_last, tx_data}, mon_exp);
        end
        if (tx_last) in_frame = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_word(input int idx, input logic [W-1:0] d, input logic l);
    int waited;
    logic rdy;
    waited = 0;
    if (idx == 0) begin
      req0_data = d; req0_last = l; req0_valid = 1'b1; exp0_q.push_back({l, d});
    end else begin
      req1_data = d; req1_last = l; req1_valid = 1'b1; exp1_q.push_back({l, d});
    end
    forever begin
      @(negedge clk);
      rdy = (idx == 0) ? req0_ready : req1_ready;
      if (rdy) break;
      waited++;
      if (waited > 300) begin
        tests++;
        failed++;
        $display("FAIL ready_timeout: req%0d waited %0d cycles, required a grant", idx, waited);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (idx == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic send_frame(input int idx, input int len, input int gap_max);
    int g;
    for (int i = 0; i < len; i++) begin
      drive_word(idx, W'($urandom_range(0, 1023)), (i == len - 1));
      g = $urandom_range(0, gap_max);
      if (g > 0 && i != len - 1) begin
        repeat (g) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp0_q.size() != 0 || exp1_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      tests++;
      failed++;
      $display("FAIL idle_timeout: busy=%0d pending=%0d, required idle", busy, exp0_q.size() + exp1_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration rule: with both valid, the one not served last wins.
  task automatic both_frames(input string name);
    int first;
    first = (pred_last == 1) ? 0 : 1;
    owner_log.delete();
    fork
      drive_word(0, W'($urandom_range(0, 1023)), 1'b1);
      drive_word(1, W'($urandom_range(0, 1023)), 1'b1);
    join
    wait_idle();
    check({name, "_count"}, owner_log.size(), 2);
    if (owner_log.size() == 2) begin
      check({name, "_first"}, owner_log[0], first);
      check({name, "_second"}, owner_log[1], 1 - first);
    end
    pred_last = 1 - first;
  endtask

  // Random transmitter behaviour during the randomized phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_env) begin
        tx_ready  = ($urandom_range(0, 3) != 0);
        tx_active = $urandom_range(0, 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    req0_data = '0; req0_valid = 1'b1; req0_last = 1'b0;
    req1_data = '0; req1_valid = 1'b1; req1_last = 1'b0;
    tx_ready = 1'b1; tx_active = 1'b0;

    // Reset state, with requests and tx_ready asserted
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_abort", tx_abort, 0);
    check("rst_error", error, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_tx_valid", tx_valid, 0);
    check("rst_hold_ready0", req0_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset_n = 1'b1;
    pred_last = 1;

    // Basic two-word frame from req0
    tx_active = 1'b1;
    owner_log.delete();
    fork
      begin
        drive_word(0, 10'h005, 1'b0);
        drive_word(0, 10'h101, 1'b1);
      end
      begin
        @(negedge clk);
        check("t1_idle_grant", grant, 0);
        check("t1_idle_valid", tx_valid, 0);
        @(negedge clk);
        check("t1_grant", grant, 2'b01);
        check("t1_valid", tx_valid, 1);
        check("t1_data0", tx_data, 10'h005);
        check("t1_ready0", req0_ready, 1);
        @(negedge clk);
        check("t1_data1", tx_data, 10'h101);
        check("t1_last1", tx_last, 1);
        @(negedge clk);
        check("t1_drain_state", state, ST_DRAIN);
        check("t1_drain_valid", tx_valid, 0);
        check("t1_drain_ready", req0_ready, 0);
        repeat (2) begin
          @(negedge clk);
          check("t1_drain_busy", busy, 1);
        end
        @(posedge clk);
        #1;
        tx_active = 1'b0;
        @(negedge clk);
        check("t1_drain_exit_busy", busy, 1);
        @(negedge clk);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_grant_clr", grant, 0);
      end
    join
    wait_idle();
    check("t1_owner", (owner_log.size() == 1) ? owner_log[0] : -1, 0);
    pred_last = 0;

    // Round-robin with both requesters valid in IDLE
    both_frames("rr_a");
    owner_log.delete();
    drive_word(0, W'($urandom_range(0, 1023)), 1'b1);
    wait_idle();
    pred_last = 0;
    both_frames("rr_b");

    // req1 raises valid mid-frame of req0
    owner_log.delete();
    fork
      begin
        drive_word(0, 10'h011, 1'b0);
        drive_word(0, 10'h022, 1'b0);
        drive_word(0, 10'h033, 1'b1);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        drive_word(1, 10'h3c4, 1'b1);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          check("t3_req1_blocked", req1_ready, 0);
        end
        @(negedge clk);
        check("t3_req1_served", req1_ready, 1);
      end
    join
    wait_idle();
    check("t3_order_count", owner_log.size(), 2);
    if (owner_log.size() == 2) check("t3_order", {owner_log[0][0], owner_log[1][0]}, 2'b01);
    pred_last = 1;

    // tx_ready low for 5 cycles in GRANT
    tx_ready = 1'b0;
    fork
      drive_word(0, 10'h2a5, 1'b1);
      begin
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("t4_hold_valid", tx_valid, 1);
          check("t4_hold_data", tx_data, 10'h2a5);
          check("t4_hold_ready", req0_ready, 0);
        end
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        @(negedge clk);
        check("t4_release_ready", req0_ready, 1);
      end
    join
    wait_idle();
    pred_last = 0;

    // Idle requester inside a granted frame
`ifdef COAX_TX_ARB_TIMEOUT_EN
    drive_word(0, 10'h155, 1'b0);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      check("t5_no_abort_yet", tx_abort, 0);
      check("t5_still_grant", state, ST_GRANT);
    end
    @(negedge clk);
    check("t5_abort", tx_abort, 1);
    @(negedge clk);
    check("t5_abort_pulse", tx_abort, 0);
    check("t5_error", error, 1);
    check("t5_drain", state, ST_DRAIN);
    @(negedge clk);
    check("t5_idle", busy, 0);
    check("t5_error_sticky", error, 1);
    in_frame = 1'b0;
    @(posedge clk);
    #1;
`else
    drive_word(0, 10'h155, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_abort_off", tx_abort, 0);
    end
    check("t5_grant_held", grant, 2'b01);
    check("t5_busy_held", busy, 1);
    check("t5_error_off", error, 0);
    @(posedge clk);
    #1;
    drive_word(0, 10'h156, 1'b1);
    wait_idle();
`endif
    pred_last = 0;

    // Asynchronous reset mid-frame
    drive_word(0, 10'h0f0, 1'b0);
    req0_valid = 1'b1;
    req0_data  = 10'h0f1;
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_grant_async", grant, 0);
    check("t6_busy_async", busy, 0);
    check("t6_valid_async", tx_valid, 0);
    check("t6_ready_async", req0_ready, 0);
    check("t6_error_async", error, 0);
    exp0_q.delete();
    exp1_q.delete();
    in_frame = 1'b0;
    req0_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    pred_last = 1;
    both_frames("t6_rr");

    // Randomized frames from both requesters
    owner_log.delete();
    rand_env = 1'b1;
    fork
      begin
        for (int f = 0; f < 12; f++) begin
          send_frame(0, $urandom_range(1, 4), 1);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
      begin
        for (int f = 0; f < 12; f++) begin
          send_frame(1, $urandom_range(1, 4), 1);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
    join
    rand_env = 1'b0;
    tx_active = 1'b0;
    tx_ready = 1'b1;
    wait_idle();
    check("rand_frames", owner_log.size(), 24);
    check("rand_q0_empty", exp0_q.size(), 0);
    check("rand_q1_empty", exp1_q.size(), 0);
    check("rand_error", error, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
